// File: rtl/fifo_stream_pkg.sv
// Shared constants and types for the FIFO-to-stream reader: buffer depth,
// occupancy count type and the pixel position record.
package fifo_stream_pkg;

  localparam int RDR_BUF_DEPTH = 2;
  localparam int CNT_W = $clog2(RDR_BUF_DEPTH + 1);

  function automatic int coord_width(input int n);
    return $clog2(n);
  endfunction

  // Position fields are sized for the largest supported image dimension.
  localparam int MAX_IMG_DIM = 65536;
  localparam int POS_W = coord_width(MAX_IMG_DIM);

  typedef logic [CNT_W-1:0] buf_cnt_t;

  typedef struct packed {
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
  } pix_pos_t;

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry in-order output buffer. Entry p0 is the head; p1 holds the
// second word. Per-entry valid bits are reset; data registers are not.
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output buf_cnt_t          count
);

  logic [DATA_W-1:0] entry_p0;
  logic [DATA_W-1:0] entry_p1;
  logic              vld_p0;
  logic              vld_p1;

  // Entry valid bits: p1 only ever holds a word while p0 does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (push && !pop) begin
      if (!vld_p0) vld_p0 <= 1'b1;
      else         vld_p1 <= 1'b1;
    end else if (pop && !push) begin
      vld_p0 <= vld_p1;
      vld_p1 <= 1'b0;
    end
  end

  // Entry data: shift p1 into the head on pop, new word lands in the tail.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (vld_p1)    entry_p0 <= entry_p1;
      else if (push) entry_p0 <= push_data;
      if (push && vld_p1) entry_p1 <= push_data;
    end else if (push) begin
      if (!vld_p0) entry_p0 <= push_data;
      else         entry_p1 <= push_data;
    end
  end

  assign head  = entry_p0;
  assign count = vld_p1 ? buf_cnt_t'(RDR_BUF_DEPTH) : buf_cnt_t'(vld_p0);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && vld_p1));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !vld_p0));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready pixel
// stream tagged with SOF/EOL/EOF. Optional counters: FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rden,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy
`ifdef FIFO_STREAM_READER_STATS_EN
 ,output logic [31:0]           stall_cnt,
  output logic [15:0]           frame_cnt
`endif
);

  localparam logic [POS_W-1:0] COL_LAST = POS_W'(IMG_WIDTH - 1);
  localparam logic [POS_W-1:0] ROW_LAST = POS_W'(IMG_HEIGHT - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  buf_cnt_t              buf_count;
  buf_cnt_t              occ;
  logic                  inflight;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  pix_pos_t              pos_q;
  logic                  col_last;
  logic                  row_last;

  assign pop = m_valid & m_ready;

  // Credit check: words buffered plus the one in flight, less this cycle's
  // pop, must leave room for the word this read will return.
  assign occ       = buf_count + buf_cnt_t'(inflight) - buf_cnt_t'(pop);
  assign fifo_rden = rst_n & enable & ~fifo_empty
                   & (occ < buf_cnt_t'(RDR_BUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rden;
  end

  fifo_stream_skid #(
    .DATA_W (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .head      (head),
    .count     (buf_count)
  );

  assign m_valid = (buf_count != '0);
  assign m_data  = m_valid ? head : '0;
  assign busy    = inflight | m_valid;

  // Position of the word currently at the head; advances only on pop.
  assign col_last = (pos_q.col == COL_LAST);
  assign row_last = (pos_q.row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else if (pop) begin
      if (col_last) begin
        pos_q.col <= '0;
        pos_q.row <= row_last ? '0 : pos_q.row + POS_ONE;
      end else begin
        pos_q.col <= pos_q.col + POS_ONE;
      end
    end
  end

  assign m_sof = m_valid & (pos_q.col == '0) & (pos_q.row == '0);
  assign m_eol = m_valid & col_last;
  assign m_eof = m_eol & row_last;

`ifdef FIFO_STREAM_READER_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Stall = downstream ready and reads permitted, but nothing to offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (m_ready & ~m_valid & enable) stall_cnt <= sat_inc32(stall_cnt);
      if (pop & m_eof)                 frame_cnt <= sat_inc16(frame_cnt);
    end
  end
`endif

endmodule
